// File: rtl/pqcuark_zetas_pkg.sv
// Shared zetas definitions: table sizes, loader states, SRAM address mapping
// and the per-scheme checksum fold used by the loader and the NTT twiddle fetch.
package pqcuark_zetas_pkg;

  localparam int unsigned KYBER_NZETAS     = 128;
  localparam int unsigned DILITHIUM_NZETAS = 256;
  localparam int unsigned ZETA_IDX_W       = 8;
  localparam int unsigned CSUM_W           = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DRAIN,
    ST_DONE
  } zl_state_e;

  // Kyber zetas sit on even addresses; the SRAM halves them internally.
  function automatic logic [ZETA_IDX_W-1:0] zeta_addr(input logic [ZETA_IDX_W-1:0] idx,
                                                       input logic                  sel_kyber);
    return sel_kyber ? {idx[ZETA_IDX_W-2:0], 1'b0} : idx;
  endfunction

  // Kyber zetas are 16-bit; the upper half of the word is ignored by the checksum.
  function automatic logic [CSUM_W-1:0] zeta_fold(input logic [CSUM_W-1:0] word,
                                                  input logic              sel_kyber);
    return sel_kyber ? {16'h0000, word[15:0]} : word;
  endfunction

endpackage

// File: rtl/zetas_loader.sv
// Zetas SRAM loader: streams N twiddle words into the SRAM, then optionally
// reads them back and compares write/read checksums before signalling done.
module zetas_loader
  import pqcuark_zetas_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  selKD_i,
  input  logic                  verify_en_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  sram_valid_o,
  output logic                  sram_selKD_o,
  output logic                  sram_rdwen_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  input  logic [DATA_WIDTH-1:0] sram_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  zl_state_e         r_state;
  logic              r_verify;
  logic              r_ret;
  logic [CNT_W-1:0]  r_cnt;
  logic [CSUM_W-1:0] r_wsum;
  logic [CSUM_W-1:0] r_rsum;

  logic [CNT_W-1:0]      w_n;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_hs;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_addr0;
  logic [CSUM_W-1:0]     w_wr_fold;
  logic [CSUM_W-1:0]     w_rd_fold;

  assign w_n       = sram_selKD_o ? CNT_W'(KYBER_NZETAS) : CNT_W'(DILITHIUM_NZETAS);
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_hs      = s_valid_i & s_ready_o;
  assign w_addr    = ADDR_WIDTH'(zeta_addr(ZETA_IDX_W'(r_cnt), sram_selKD_o));
  assign w_addr0   = ADDR_WIDTH'(zeta_addr(ZETA_IDX_W'(0), sram_selKD_o));
  assign w_wr_fold = zeta_fold(CSUM_W'(s_data_i), sram_selKD_o);
  assign w_rd_fold = zeta_fold(CSUM_W'(sram_data_i), sram_selKD_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_verify     <= 1'b0;
      r_ret        <= 1'b0;
      r_cnt        <= '0;
      r_wsum       <= '0;
      r_rsum       <= '0;
      s_ready_o    <= 1'b0;
      sram_valid_o <= 1'b0;
      sram_selKD_o <= 1'b0;
      sram_rdwen_o <= 1'b0;
      sram_addr_o  <= '0;
      sram_data_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      sram_valid_o <= 1'b0;
      sram_rdwen_o <= 1'b0;
      done_o       <= 1'b0;
      // Read data arrives the cycle after the read was on the port.
      r_ret        <= sram_valid_o & ~sram_rdwen_o;
      if (r_ret) begin
        r_rsum <= r_rsum + w_rd_fold;
      end

      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            sram_selKD_o <= selKD_i;
            r_verify     <= verify_en_i;
            r_cnt        <= '0;
            r_wsum       <= '0;
            r_rsum       <= '0;
            err_o        <= 1'b0;
            s_ready_o    <= 1'b1;
            busy_o       <= 1'b1;
            r_state      <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (w_hs) begin
            sram_valid_o <= 1'b1;
            sram_rdwen_o <= 1'b1;
            sram_addr_o  <= w_addr;
            sram_data_o  <= s_data_i;
            r_wsum       <= r_wsum + w_wr_fold;
            r_cnt        <= w_cnt_nxt;
            if (w_cnt_nxt == w_n) begin
              s_ready_o <= 1'b0;
            end
          end else if (r_cnt == w_n) begin
            // Last write is on the port this cycle; first read follows it directly.
            if (r_verify) begin
              sram_valid_o <= 1'b1;
              sram_addr_o  <= w_addr0;
              r_cnt        <= CNT_W'(1);
              r_state      <= ST_VERIFY;
            end else begin
              done_o  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end

        ST_VERIFY: begin
          if (r_cnt != w_n) begin
            sram_valid_o <= 1'b1;
            sram_addr_o  <= w_addr;
            r_cnt        <= w_cnt_nxt;
          end else begin
            r_state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          err_o   <= (r_wsum != (r_rsum + w_rd_fold));
          done_o  <= 1'b1;
          r_state <= ST_DONE;
        end

        ST_DONE: begin
          busy_o  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zetas_loader.sv
// Randomized bench for zetas_loader with a behavioural SRAM and a word-list
// reference model of addresses, write timing, read-back order and checksums.
module tb_zetas_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        selKD_i;
  logic        verify_en_i;
  logic        s_valid_i;
  logic [31:0] s_data_i;
  logic        s_ready_o;
  logic        sram_valid_o;
  logic        sram_selKD_o;
  logic        sram_rdwen_o;
  logic [7:0]  sram_addr_o;
  logic [31:0] sram_data_o;
  logic [31:0] sram_data_i = '0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int n_chk  = 0;
  int n_pass = 0;
  int corrupt_addr = -1;
  logic [31:0] mem [256];

  zetas_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .selKD_i      (selKD_i),
    .verify_en_i  (verify_en_i),
    .s_valid_i    (s_valid_i),
    .s_data_i     (s_data_i),
    .s_ready_o    (s_ready_o),
    .sram_valid_o (sram_valid_o),
    .sram_selKD_o (sram_selKD_o),
    .sram_rdwen_o (sram_rdwen_o),
    .sram_addr_o  (sram_addr_o),
    .sram_data_o  (sram_data_o),
    .sram_data_i  (sram_data_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural SRAM, 1-cycle read latency, optional single-address bit flip on read.
  always @(posedge clk_i) begin
    if (sram_valid_o && sram_rdwen_o) mem[sram_addr_o] <= sram_data_o;
    if (sram_valid_o && !sram_rdwen_o)
      sram_data_i <= mem[sram_addr_o] ^ ((int'(sram_addr_o) == corrupt_addr) ? 32'h0000_0008 : 32'h0);
    else
      sram_data_i <= '0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int exp_addr(input bit kyb, input int k);
    return kyb ? 2 * k : k;
  endfunction

  function automatic logic [31:0] fold(input bit kyb, input logic [31:0] w);
    return kyb ? (w & 32'h0000_FFFF) : w;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // mode: 0 = 0x1000+k, 1 = 3k, 2 = 0xDEAD upper + random low, 3 = random.
  task automatic run_load(input bit kyb, input bit ver, input int corrupt_k,
                          input int gap_pct, input int mode, input bit disturb);
    int n;
    int k;
    int rd_seen;
    int last_hs;
    int first_rd;
    int last_rd;
    int done_cyc;
    bit prev_hs;
    bit hs;
    logic [31:0] prev_data;
    logic [31:0] w;
    logic [31:0] sum_w;
    logic [31:0] sum_r;
    logic [31:0] words[$];
    bit mem_ok;

    n = kyb ? 128 : 256;
    k = 0; rd_seen = 0; last_hs = -1; first_rd = -1; last_rd = -1; done_cyc = -1;
    prev_hs = 0; prev_data = '0;
    corrupt_addr = (corrupt_k >= 0) ? exp_addr(kyb, corrupt_k) : -1;

    start_i = 1'b1; selKD_i = kyb; verify_en_i = ver; s_valid_i = 1'b0;
    tick();
    start_i = 1'b0; verify_en_i = ~ver;
    chk("busy_after_start", {31'b0, busy_o}, 32'd1);
    chk("err_cleared_by_start", {31'b0, err_o}, 32'd0);
    chk("latched_scheme", {31'b0, sram_selKD_o}, {31'b0, kyb});

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_hs) begin
        chk("wr_strobe", {30'b0, sram_valid_o, sram_rdwen_o}, 32'd3);
        chk("wr_addr", {24'b0, sram_addr_o}, 32'(exp_addr(kyb, k - 1)));
        chk("wr_data", sram_data_o, prev_data);
        chk("wr_scheme", {31'b0, sram_selKD_o}, {31'b0, kyb});
      end else if (sram_valid_o && sram_rdwen_o) begin
        chk("spurious_write", 32'd1, 32'd0);
      end
      if (sram_valid_o && !sram_rdwen_o) begin
        if (rd_seen == 0) begin
          first_rd = cyc;
          chk("first_read_cycle", 32'(cyc), 32'(last_hs + 2));
        end
        chk("rd_back_to_back", 32'(cyc), 32'(first_rd + rd_seen));
        chk("rd_addr", {24'b0, sram_addr_o}, 32'(exp_addr(kyb, rd_seen)));
        rd_seen++;
        last_rd = cyc;
      end
      if (done_o) begin
        done_cyc = cyc;
        break;
      end

      hs = 1'b0;
      if (disturb) begin
        start_i = (k == 60);
        if (k >= 60) selKD_i = ~kyb;
      end
      if (k < n) begin
        s_valid_i = ($urandom_range(99) >= gap_pct);
        case (mode)
          0: w = 32'h0000_1000 + 32'(k);
          1: w = 32'(k * 3);
          2: w = {16'hDEAD, 16'($urandom)};
          default: w = $urandom;
        endcase
        s_data_i = w;
        hs = s_valid_i & s_ready_o;
        if (hs) begin
          words.push_back(w);
          k++;
          last_hs = cyc;
        end
      end else begin
        s_valid_i = 1'b0;
        chk("ready_low_when_full", {31'b0, s_ready_o}, 32'd0);
      end
      prev_hs = hs;
      prev_data = w;
      tick();
    end
    start_i = 1'b0; s_valid_i = 1'b0;

    if (done_cyc < 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    chk("words_accepted", 32'(k), 32'(n));
    if (ver) begin
      chk("reads_issued", 32'(rd_seen), 32'(n));
      chk("done_after_last_read", 32'(done_cyc), 32'(last_rd + 2));
    end else begin
      chk("no_reads", 32'(rd_seen), 32'd0);
      chk("done_after_last_hs", 32'(done_cyc), 32'(last_hs + 2));
    end

    sum_w = '0; sum_r = '0; mem_ok = 1;
    foreach (words[i]) begin
      sum_w += fold(kyb, words[i]);
      sum_r += fold(kyb, words[i] ^ ((i == corrupt_k) ? 32'h8 : 32'h0));
      if (mem[exp_addr(kyb, i)] !== words[i]) mem_ok = 0;
    end
    chk("sram_contents", {31'b0, mem_ok}, 32'd1);
    chk("err_at_done", {31'b0, err_o}, {31'b0, (ver && (sum_w != sum_r))});
    chk("busy_at_done", {31'b0, busy_o}, 32'd1);

    tick();
    chk("done_one_cycle", {31'b0, done_o}, 32'd0);
    chk("busy_idle", {31'b0, busy_o}, 32'd0);
    chk("ready_idle", {31'b0, s_ready_o}, 32'd0);
    corrupt_addr = -1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, {24'b0, s_ready_o, sram_valid_o, sram_selKD_o, sram_rdwen_o,
                         busy_o, done_o, err_o, 1'b0}, 32'd0);
    chk({tag, "_addr"}, {24'b0, sram_addr_o}, 32'd0);
    chk({tag, "_data"}, sram_data_o, 32'd0);
  endtask

  initial begin
    int hs_cnt;
    bit hit;
    rst_i = 1'b1; start_i = 1'b0; selKD_i = 1'b0; verify_en_i = 1'b0;
    s_valid_i = 1'b0; s_data_i = '0;
    foreach (mem[i]) mem[i] = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_i = 1'b0;
    tick();

    run_load(1'b1, 1'b0, -1, 0, 0, 1'b0);
    run_load(1'b0, 1'b1, -1, 0, 1, 1'b0);
    run_load(1'b0, 1'b1, 17, 0, 3, 1'b0);
    repeat (3) begin
      tick();
      chk("err_sticky", {31'b0, err_o}, 32'd1);
    end
    run_load(1'b1, 1'b1, -1, 35, 2, 1'b0);
    run_load(1'b0, 1'b0, -1, 25, 3, 1'b1);
    run_load(1'b1, 1'b1, -1, 20, 3, 1'b1);

    // Abort at the 50th handshake.
    start_i = 1'b1; selKD_i = 1'b0; verify_en_i = 1'b1;
    tick();
    start_i = 1'b0;
    hs_cnt = 0; hit = 0;
    for (int c = 0; c < 500 && !hit; c++) begin
      s_valid_i = 1'b1;
      s_data_i = $urandom;
      if (s_ready_o) hs_cnt++;
      if (hs_cnt == 50) begin
        rst_i = 1'b1;
        hit = 1;
      end
      tick();
    end
    chk("rst_reached", {31'b0, hit}, 32'd1);
    s_valid_i = 1'b0;
    check_all_zero("abort");
    rst_i = 1'b0;
    tick();
    check_all_zero("abort_idle");
    run_load(1'b1, 1'b0, -1, 15, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
